// File: rtl/db15_pad_scanner.sv
// Scans two daisy-chained DB15 pads (32 serial bits), two-scan filtered; outputs update 1 MCLK after each scan's UPDATE.
// Latency: a steady change appears at the second complete scan after the pads latch it. No backpressure: free-running.
module db15_pad_scanner #(
  parameter int CLK_DIV   = 24,
  parameter int GAP_TICKS = 64
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        scan_done
);

  typedef enum logic [2:0] {S_GAP, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_UPDATE} state_t;

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
  localparam logic [9:0] GAP_MAX = 10'(GAP_TICKS - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [9:0]  gap_q, gap_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] prev_q, prev_d;
  logic [15:0] joy1_q, joy1_d;
  logic [15:0] joy2_q, joy2_d;
  logic [1:0]  sync_q, sync_d;
  logic        jclk_q, jclk_d;
  logic        jload_q, jload_d;
  logic        done_q, done_d;
  logic        tick;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    prev_d  = prev_q;
    joy1_d  = joy1_q;
    joy2_d  = joy2_q;
    done_d  = 1'b0;
    sync_d  = {sync_q[0], JOY_DATA};
    tick    = (div_q == DIV_MAX);

    // Divider is frozen in UPDATE, which makes every scan one MCLK longer than its tick count.
    if (state_q != S_UPDATE) begin
      div_d = tick ? 8'd0 : div_q + 8'd1;
    end

    case (state_q)
      S_GAP: begin
        if (tick) begin
          if (gap_q == GAP_MAX) begin
            state_d = S_LOAD;
            bit_d   = 5'd0;
          end else begin
            gap_d = gap_q + 10'd1;
          end
        end
      end
      // Bit counter doubles as the two-tick load timer.
      S_LOAD: begin
        if (tick) begin
          if (bit_q == 5'd1) begin
            state_d = S_SHIFT_LO;
            bit_d   = 5'd0;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end
      S_SHIFT_LO: begin
        if (tick) begin
          sh_d    = {sh_q[30:0], sync_q[1]};
          state_d = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (tick) begin
          if (bit_q == 5'd31) begin
            state_d = S_UPDATE;
          end else begin
            bit_d   = bit_q + 5'd1;
            state_d = S_SHIFT_LO;
          end
        end
      end
      S_UPDATE: begin
        done_d = 1'b1;
        if (sh_q == prev_q) begin
          joy1_d = ~sh_q[31:16];
          joy2_d = ~sh_q[15:0];
        end
        prev_d  = sh_q;
        gap_d   = 10'd0;
        state_d = S_GAP;
      end
      default: state_d = S_GAP;
    endcase

    // Pins are registered from the next state so they change on the same edge as the state.
    jclk_d  = (state_d != S_SHIFT_LO);
    jload_d = (state_d != S_LOAD);
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_GAP;
      div_q   <= 8'd0;
      bit_q   <= 5'd0;
      gap_q   <= 10'd0;
      sh_q    <= 32'd0;
      prev_q  <= 32'd0;
      joy1_q  <= 16'd0;
      joy2_q  <= 16'd0;
      sync_q  <= 2'b11;
      jclk_q  <= 1'b1;
      jload_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      prev_q  <= prev_d;
      joy1_q  <= joy1_d;
      joy2_q  <= joy2_d;
      sync_q  <= sync_d;
      jclk_q  <= jclk_d;
      jload_q <= jload_d;
      done_q  <= done_d;
    end
  end

  assign JOY_CLK   = jclk_q;
  assign JOY_LOAD  = jload_q;
  assign joystick1 = joy1_q;
  assign joystick2 = joy2_q;
  assign scan_done = done_q;

endmodule

// File: tb/tb_db15_pad_scanner.sv
// Bench for db15_pad_scanner: 74HC165 chain models feed queued patterns; a scoreboard checks outputs at every scan_done.
module tb_db15_pad_scanner;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic rst_a, rst_b;
  logic clk_a, load_a, done_a, clk_b, load_b, done_b;
  logic [15:0] j1_a, j2_a, j1_b, j2_b;
  logic [31:0] pad_a = '1;
  logic [31:0] pad_b = '1;
  logic data_a, data_b;

  db15_pad_scanner #(.CLK_DIV(24), .GAP_TICKS(64)) u_dut (
    .MCLK(mclk), .RESET(rst_a), .JOY_DATA(data_a), .JOY_CLK(clk_a), .JOY_LOAD(load_a),
    .joystick1(j1_a), .joystick2(j2_a), .scan_done(done_a));

  db15_pad_scanner #(.CLK_DIV(2), .GAP_TICKS(1)) u_fast (
    .MCLK(mclk), .RESET(rst_b), .JOY_DATA(data_b), .JOY_CLK(clk_b), .JOY_LOAD(load_b),
    .joystick1(j1_b), .joystick2(j2_b), .scan_done(done_b));

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] pat_a[$], pat_b[$], exp_a[$], exp_b[$];

  // Pad chain: parallel load while LOAD is low, shift on JOY_CLK rise, ones shifted in.
  always @(negedge load_a) pad_a = (pat_a.size() != 0) ? pat_a.pop_front() : 32'hFFFF_FFFF;
  always @(posedge clk_a) if (load_a) pad_a = {pad_a[30:0], 1'b1};
  assign data_a = pad_a[31];
  always @(negedge load_b) pad_b = (pat_b.size() != 0) ? pat_b.pop_front() : 32'hFFFF_FFFF;
  always @(posedge clk_b) if (load_b) pad_b = {pad_b[30:0], 1'b1};
  assign data_b = pad_b[31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Scoreboard monitors
  always @(negedge mclk) begin
    if (done_a) begin
      if (exp_a.size() == 0) flag("a_spurious_done", "scan_done with no scan expected");
      else chk("a_joy", {j1_a, j2_a}, exp_a.pop_front());
    end
    if (done_b) begin
      if (exp_b.size() == 0) flag("b_spurious_done", "scan_done with no scan expected");
      else chk("b_joy", {j1_b, j2_b}, exp_b.pop_front());
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0: return load_a;
      1: return clk_a;
      2: return done_a;
      3: return load_b;
      4: return done_b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_level(input int sel, input logic lvl, input int budget);
    int n = 0;
    while (sig(sel) !== lvl && n < budget) begin
      @(negedge mclk);
      n++;
    end
    if (sig(sel) !== lvl) begin
      checks++;
      errors++;
      $display("FAIL wait_sel%0d: level %0b not reached within %0d cycles", sel, lvl, budget);
    end
  endtask

  task automatic drain(input int sel, input int budget);
    int n = 0;
    while (((sel == 0) ? exp_a.size() : exp_b.size()) != 0 && n < budget) begin
      @(negedge mclk);
      n++;
    end
    if (((sel == 0) ? exp_a.size() : exp_b.size()) != 0)
      flag("drain", $sformatf("scoreboard %0d still holds entries after %0d cycles", sel, budget));
  endtask

  // {pattern, expected {joystick1, joystick2}} for scans 2..11 of the main run
  logic [63:0] scan_tbl [10] = '{
    {32'hFFFF_FFFF, 32'h0000_0000},   // disconnected twice -> zero
    {32'hFFFE_7FFF, 32'h0000_0000},
    {32'hFFFE_7FFF, 32'h0001_8000},
    {32'h5A5A_C3C3, 32'h0001_8000},   // pattern A, first scan holds
    {32'h5A5A_C3C3, 32'hA5A5_3C3C},
    {32'h5A5A_C3E3, 32'hA5A5_3C3C},   // bit 5 glitch filtered
    {32'h5A5A_C3C3, 32'hA5A5_3C3C},
    {32'h5A5A_C3C3, 32'hA5A5_3C3C},
    {32'h1234_8765, 32'hA5A5_3C3C},   // pattern B, first scan holds
    {32'h1234_8765, 32'hEDCB_789A}
  };

  initial begin
    int t0, ts, good;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge mclk);
    #1;
    chk("rst_joy_clk", {31'd0, clk_a}, 32'd1);
    chk("rst_joy_load", {31'd0, load_a}, 32'd1);
    chk("rst_joy", {j1_a, j2_a}, 32'd0);
    chk("rst_scan_done", {31'd0, done_a}, 32'd0);

    // Timing of the first scan with the chain reading all ones
    exp_a.push_back(32'd0);
    @(posedge mclk);
    #1 rst_a = 1'b0;
    t0 = cyc;
    wait_level(0, 1'b0, 5000);
    chk("a_first_load", cyc - t0, 1536);
    ts = cyc;
    wait_level(0, 1'b1, 200);
    chk("a_load_width", cyc - ts, 48);
    good = 0;
    for (int i = 0; i < 32; i++) begin
      wait_level(1, 1'b0, 200);
      ts = cyc;
      wait_level(1, 1'b1, 200);
      if (cyc - ts == 24) good++;
    end
    chk("a_clk_pulses_24", good, 32);
    ts = cyc;
    wait_level(2, 1'b1, 200);
    chk("a_done_delay", cyc - ts, 25);

    foreach (scan_tbl[i]) begin
      pat_a.push_back(scan_tbl[i][63:32]);
      exp_a.push_back(scan_tbl[i][31:0]);
    end
    drain(0, 40000);

    // Reset in the middle of bit 17
    pat_a.push_back(32'h0000_FFFF);
    wait_level(0, 1'b0, 5000);
    wait_level(0, 1'b1, 200);
    for (int i = 0; i < 17; i++) begin
      wait_level(1, 1'b0, 200);
      wait_level(1, 1'b1, 200);
    end
    wait_level(1, 1'b0, 200);
    repeat (5) @(negedge mclk);
    #2 rst_a = 1'b1;
    #1;
    chk("midrst_joy_clk", {31'd0, clk_a}, 32'd1);
    chk("midrst_joy_load", {31'd0, load_a}, 32'd1);
    chk("midrst_joy", {j1_a, j2_a}, 32'd0);
    repeat (4) @(posedge mclk);
    pat_a.push_back(32'h6996_F00F);
    exp_a.push_back(32'h0000_0000);
    pat_a.push_back(32'h6996_F00F);
    exp_a.push_back(32'h9669_0FF0);
    #1 rst_a = 1'b0;
    t0 = cyc;
    wait_level(0, 1'b0, 5000);
    chk("a_load_after_rst", cyc - t0, 1536);
    drain(0, 8000);

    // Fast instance: CLK_DIV=2, GAP_TICKS=1
    for (int i = 0; i < 3; i++) pat_b.push_back(32'h3C71_9E2B);
    exp_b.push_back(32'h0000_0000);
    exp_b.push_back(32'hC38E_61D4);
    exp_b.push_back(32'hC38E_61D4);
    @(posedge mclk);
    #1 rst_b = 1'b0;
    t0 = cyc;
    wait_level(3, 1'b0, 100);
    chk("b_first_load", cyc - t0, 2);
    wait_level(4, 1'b1, 300);
    for (int i = 0; i < 2; i++) begin
      ts = cyc;
      wait_level(4, 1'b0, 10);
      wait_level(4, 1'b1, 300);
      chk("b_scan_period", cyc - ts, 135);
    end
    drain(1, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
